fft_complex_mult: RTL and testbench

Pipelined fixed-point complex multiplier for the FFT datapath. It computes the twiddle product w·b consumed by the butterfly (`fft_bfu`). It carries each sample's FFT index alongside the data and outputs that index bit-reversed, so the product and its reordered address leave the block aligned. The bit-reverse function is a reusable combinational sub-module, `reindex_bits`.

---
 rtl/fft_pkg.sv | 32 +++
 rtl/reindex_bits.sv | 13 +
 rtl/fft_complex_mult.sv | 91 +++++++++
 tb/tb_fft_complex_mult.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT datapath types and helpers: complex word layout, component
// accessors and a Q1.15 saturator used by the multiplier, butterfly and twiddle ROM.
package fft_pkg;

  localparam int BIT_WIDTH = 16;
  localparam int FFT_L     = 11;

  typedef struct packed {
    logic signed [BIT_WIDTH-1:0] re;
    logic signed [BIT_WIDTH-1:0] im;
  } cplx_t;

  localparam logic signed [2*BIT_WIDTH:0] SAT_HI = (2*BIT_WIDTH+1)'((1 << (BIT_WIDTH-1)) - 1);
  localparam logic signed [2*BIT_WIDTH:0] SAT_LO = -SAT_HI - (2*BIT_WIDTH+1)'(1);

  function automatic logic signed [BIT_WIDTH-1:0] cplx_re(input cplx_t c);
    return c.re;
  endfunction

  function automatic logic signed [BIT_WIDTH-1:0] cplx_im(input cplx_t c);
    return c.im;
  endfunction

  function automatic logic signed [BIT_WIDTH-1:0] saturate(input logic signed [2*BIT_WIDTH:0] x);
    logic signed [2*BIT_WIDTH:0] t;
    if (x > SAT_HI)      t = SAT_HI;
    else if (x < SAT_LO) t = SAT_LO;
    else                 t = x;
    return t[BIT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/reindex_bits.sv
// Combinational bit-reversal of an L-bit FFT index; shared with the address generator.
module reindex_bits #(
  parameter int L = 11
) (
  input  logic [L-1:0] in,
  output logic [L-1:0] out
);

  for (genvar k = 0; k < L; k++) begin : g_rev
    assign out[k] = in[L-1-k];
  end

endmodule

// File: rtl/fft_complex_mult.sv
// Two-stage pipelined complex multiply w*b with round-half-up and saturation;
// the sample index travels alongside, bit-reversed, so product and address stay aligned.
module fft_complex_mult
  import fft_pkg::*;
#(
  parameter int bit_width = BIT_WIDTH,
  parameter int L         = FFT_L
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_in,
  input  logic [2*bit_width-1:0] b,
  input  logic [2*bit_width-1:0] twiddle,
  input  logic [L-1:0]           idx_in,
  output logic                   valid_out,
  output logic [2*bit_width-1:0] prod,
  output logic [L-1:0]           idx_out
);

  localparam int PW = 2*bit_width;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] RND     = SW'(1) <<< (bit_width-2);
  localparam logic signed [SW-1:0] SAT_MAX = (SW'(1) <<< (bit_width-1)) - SW'(1);
  localparam logic signed [SW-1:0] SAT_MIN = -(SW'(1) <<< (bit_width-1));

  // Add half an output LSB, arithmetic-shift back to Q1.(bit_width-1), clamp.
  function automatic logic signed [bit_width-1:0] round_sat(input logic signed [SW-1:0] x);
    logic signed [SW-1:0] t;
    t = (x + RND) >>> (bit_width-1);
    if (t > SAT_MAX)      t = SAT_MAX;
    else if (t < SAT_MIN) t = SAT_MIN;
    return t[bit_width-1:0];
  endfunction

  logic signed [bit_width-1:0] w_br, w_bi, w_wr, w_wi;
  logic [L-1:0]                w_idx_rev;

  assign w_br = b[PW-1:bit_width];
  assign w_bi = b[bit_width-1:0];
  assign w_wr = twiddle[PW-1:bit_width];
  assign w_wi = twiddle[bit_width-1:0];

  reindex_bits #(.L(L)) u_reindex (
    .in  (idx_in),
    .out (w_idx_rev)
  );

  logic signed [PW-1:0]        r_rr_p1, r_ii_p1, r_ri_p1, r_ir_p1;
  logic                        r_vld_p1;
  logic [L-1:0]                r_idx_p1;
  logic signed [bit_width-1:0] r_re_p2, r_im_p2;
  logic                        r_vld_p2;
  logic [L-1:0]                r_idx_p2;
  logic signed [SW-1:0]        w_re_sum, w_im_sum;

  assign w_re_sum = SW'(r_rr_p1) - SW'(r_ii_p1);
  assign w_im_sum = SW'(r_ri_p1) + SW'(r_ir_p1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_p1  <= '0;
      r_ii_p1  <= '0;
      r_ri_p1  <= '0;
      r_ir_p1  <= '0;
      r_vld_p1 <= 1'b0;
      r_idx_p1 <= '0;
      r_re_p2  <= '0;
      r_im_p2  <= '0;
      r_vld_p2 <= 1'b0;
      r_idx_p2 <= '0;
    end else begin
      // stage 1: full-precision partial products
      r_rr_p1  <= PW'(w_br) * PW'(w_wr);
      r_ii_p1  <= PW'(w_bi) * PW'(w_wi);
      r_ri_p1  <= PW'(w_br) * PW'(w_wi);
      r_ir_p1  <= PW'(w_bi) * PW'(w_wr);
      r_vld_p1 <= valid_in;
      r_idx_p1 <= w_idx_rev;
      // stage 2: widened sums, rounded and saturated per lane
      r_re_p2  <= round_sat(w_re_sum);
      r_im_p2  <= round_sat(w_im_sum);
      r_vld_p2 <= r_vld_p1;
      r_idx_p2 <= r_idx_p1;
    end
  end

  assign prod      = {r_re_p2, r_im_p2};
  assign valid_out = r_vld_p2;
  assign idx_out   = r_idx_p2;

endmodule

// File: tb/tb_fft_complex_mult.sv
// Directed and randomized checks of fft_complex_mult against an integer-arithmetic model.
module tb_fft_complex_mult;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] b;
  logic [31:0] twiddle;
  logic [10:0] idx_in;
  logic        valid_out;
  logic [31:0] prod;
  logic [10:0] idx_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic        pend_v;
  logic [31:0] pend_p;
  logic [10:0] pend_i;

  always #5 clk = ~clk;

  fft_complex_mult #(.bit_width(16), .L(11)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .b         (b),
    .twiddle   (twiddle),
    .idx_in    (idx_in),
    .valid_out (valid_out),
    .prod      (prod),
    .idx_out   (idx_out)
  );

  function automatic logic [15:0] rescale(input longint x);
    longint y;
    y = (x + 64'sd16384) >>> 15;
    if (y > 64'sd32767)  y = 64'sd32767;
    if (y < -64'sd32768) y = -64'sd32768;
    return y[15:0];
  endfunction

  function automatic logic [31:0] model_prod(input logic [15:0] br, bi, wr, wi);
    longint sbr, sbi, swr, swi;
    sbr = longint'($signed(br));
    sbi = longint'($signed(bi));
    swr = longint'($signed(wr));
    swi = longint'($signed(wi));
    return {rescale(sbr*swr - sbi*swi), rescale(sbr*swi + sbi*swr)};
  endfunction

  function automatic logic [10:0] model_rev(input logic [10:0] x);
    logic [10:0] r;
    for (int k = 0; k < 11; k++) r[k] = x[10-k];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance, then compare against what the model says is in the output stage.
  task automatic cycle(input logic rst, input logic v, input logic [15:0] br, bi, wr, wi,
                       input logic [10:0] idx);
    logic        ev;
    logic [31:0] ep;
    logic [10:0] ei;
    reset = rst; valid_in = v; b = {br, bi}; twiddle = {wr, wi}; idx_in = idx;
    @(posedge clk);
    #1;
    if (rst) begin
      ev = 1'b0; ep = '0; ei = '0;
      pend_v = 1'b0; pend_p = '0; pend_i = '0;
    end else begin
      ev = pend_v; ep = pend_p; ei = pend_i;
      pend_v = v; pend_p = model_prod(br, bi, wr, wi); pend_i = model_rev(idx);
    end
    chk("valid_out", {31'b0, valid_out}, {31'b0, ev});
    chk("prod", prod, ep);
    chk("idx_out", {21'b0, idx_out}, {21'b0, ei});
  endtask

  function automatic logic [15:0] rnd16();
    logic [31:0] r;
    r = $urandom;
    case (r[3:0])
      4'd0:    return 16'h8000;
      4'd1:    return 16'h7FFF;
      4'd2:    return 16'h0001;
      default: return r[31:16];
    endcase
  endfunction

  task automatic directed(input logic [15:0] br, bi, wr, wi, input logic [10:0] idx,
                          input logic [15:0] ere, eim, input logic [10:0] eidx, input string tag);
    cycle(1'b0, 1'b1, br, bi, wr, wi, idx);
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 11'h0);
    chk({tag, "_vld"}, {31'b0, valid_out}, 32'd1);
    chk({tag, "_prod"}, prod, {ere, eim});
    chk({tag, "_idx"}, {21'b0, idx_out}, {21'b0, eidx});
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; b = '0; twiddle = '0; idx_in = '0;
    cycle(1'b1, 1'b1, 16'h1234, 16'h5678, 16'h4000, 16'h4000, 11'h7FF);
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 11'h0);
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 11'h0);
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 11'h0);

    directed(16'h4000, 16'h0000, 16'h4000, 16'h0000, 11'b10101010101,
             16'h2000, 16'h0000, 11'b10101010101, "half_sq");
    directed(16'h4000, 16'h4000, 16'h0000, 16'h4000, 11'b00000000001,
             16'hE000, 16'h2000, 11'b10000000000, "rot_j");
    directed(16'h8000, 16'h8000, 16'h8000, 16'h8000, 11'b00000000110,
             16'h0000, 16'h7FFF, 11'b01100000000, "sat_im");
    directed(16'h8000, 16'h0000, 16'h8000, 16'h0000, 11'h000,
             16'h7FFF, 16'h0000, 11'h000, "sat_re");
    directed(16'h0001, 16'h0000, 16'h4000, 16'h0000, 11'h000,
             16'h0001, 16'h0000, 11'h000, "round_half");

    // 8 back-to-back valid samples, then drain.
    for (int i = 0; i < 8; i++)
      cycle(1'b0, 1'b1, rnd16(), rnd16(), rnd16(), rnd16(), 11'(i));
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b0, rnd16(), rnd16(), rnd16(), rnd16(), 11'($urandom));

    // Reset on the 4th cycle of a stream with valid held high.
    for (int i = 0; i < 8; i++)
      cycle(i == 3, 1'b1, rnd16(), rnd16(), rnd16(), rnd16(), 11'($urandom));
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b0, rnd16(), rnd16(), rnd16(), rnd16(), 11'($urandom));

    // Random traffic with random valid and occasional reset.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      cycle(r == 8'd0, r[0] | r[1], rnd16(), rnd16(), rnd16(), rnd16(), 11'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
